ecc_encoder_pipe: RTL and testbench
===================================

// Module: ecc_encoder_pipe
// PURPOSE
//  Hamming SEC check-bit generator: the write-side partner of the ECC correcting decoder.
//  Accepts DATA_WIDTH-bit words on a valid/ready stream, computes ECC_WIDTH check bits.
//  Emits {data, ecc} two cycles later, in a form the decoder accepts directly.
//  Sits in front of memory/link writes. Includes a test error-injection path so the decoder can be exercised in-system.
// PARAMETERS
//  DATA_WIDTH  32  payload width in bits; legal range 4..64
//  ECC_WIDTH   6   check bits; smallest p with 2**p >= DATA_WIDTH+p+1 (elaboration error if not)
// PORTS
//  clk        in   1           rising-edge clock
//  rstb       in   1           asynchronous active-low reset
//  in_valid   in   1           input word valid
//  in_ready   out  1           encoder can accept a word this cycle
//  in_data    in   DATA_WIDTH  payload
//  inj_en     in   1           XOR inj_mask into the outgoing codeword of the word accepted this cycle
//  inj_mask   in   DATA_WIDTH+ECC_WIDTH  {data_mask, ecc_mask} error pattern
//  out_valid  out  1           output codeword valid
//  out_ready  in   1           downstream accepts
//  out_data   out  DATA_WIDTH  payload (with data_mask applied if injected)
//  out_ecc    out  ECC_WIDTH   check bits (with ecc_mask applied if injected)
//  word_cnt   out  16          count of codewords delivered (out_valid&&out_ready); wraps FFFF->0
// BEHAVIOUR
//  - Reset (rstb=0, async): out_valid=0, out_data=0, out_ecc=0, word_cnt=0, both stage-valid flags cleared; in_ready=1 after release.
//  - Codeword layout: positions 1..DATA_WIDTH+ECC_WIDTH; power-of-two positions hold check bits.
//  - Data bits fill the remaining positions in ascending order, data[0] at position 3.
//  - ecc[i] = XOR of all data bits whose position has bit i set (even parity).
//  - Pipeline S1: register data, mask, inj flag. S2: register computed ecc and data, apply mask, present outputs.
//  - Latency: 2 clocks from input handshake to out_valid, with no backpressure.
//  - Throughput: 1 word/clock while out_ready=1.
//  - in_ready = !s1_valid || (!s2_valid || out_ready), i.e. stall propagates combinationally back, no bubbles.
//  - Stage advance: S2 loads from S1 when !s2_valid || out_ready; S1 loads from the input on in_valid&&in_ready.
//  - Output hold: while out_valid=1 && out_ready=0, out_data and out_ecc are stable and out_valid stays 1.
//  - Injection is sampled with the word, at the input handshake; inj_en/inj_mask are ignored when there is no handshake.
//  - word_cnt increments on out_valid&&out_ready, wrap-around is silent.
//  - Simultaneous handshakes: input and output handshake in the same cycle with the pipe full -> both words move, occupancy unchanged.
//  - Reset mid-stream: in-flight words are discarded, not flushed; no partial output after rstb rises.
// STRUCTURE
//  - ecc_pkg:
//    - function ecc_width(dw) -> p
//    - function data_pos(idx) -> codeword position
//    - function gen_ecc(data) -> check bits
//    - The decoder imports the same package so the two ends cannot disagree.
//  - Sub-module ecc_parity_gen: combinational data->ecc using ecc_pkg, instantiated between S1 and S2.
//  - Handshake/counter logic stays in the top module.
// TESTING
//  - Reset, then send 32'h0000_0000 -> out_ecc=6'b000000 after 2 clocks; word_cnt=1.
//  - 32'h0000_0001 -> 6'b000011; 32'h0000_0002 -> 6'b000101; 32'h0000_0003 -> 6'b000110; 32'h8000_0000 -> 6'b100110.
//  - Burst of 100 random words, out_ready=1:
//    - one codeword per clock after a 2-clock fill;
//    - each {out_data, out_ecc} fed to the decoder returns the original data;
//    - word_cnt=100.
//  - Backpressure: random out_ready at 50%:
//    - no word lost or duplicated, order preserved;
//    - outputs stable while stalled;
//    - in_ready=0 only when both stages are full and out_ready=0.
//  - Injection: 32'h0000_00C5 with inj_mask bit 5 of the data field set -> decoder output equals 32'h0000_00C5.
//    The same with a single ecc-field bit -> also corrected.
//  - Async reset asserted with 2 words in flight -> out_valid=0 immediately; after release, no stale word emitted.
//  - Counter: word_cnt preloaded via force to 16'hFFFF, then one delivery -> 16'h0000.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared Hamming SEC layout and check-bit helpers for the encoder and the decoder.
package ecc_pkg;
  localparam int MAX_DW = 64;
  localparam int MAX_EW = 7;
  function automatic int ecc_width(input int dw);
    int p = 0;
    for (int k = 7; k >= 1; k--) if ((1 << k) >= dw + k + 1) p = k;
    return p;
  endfunction
  // Power-of-two positions are check bits; data fills the rest from position 3 up.
  function automatic int data_pos(input int idx);
    int n = 0;
    int r = 0;
    for (int p = 3; p < 128; p++) if ((p & (p - 1)) != 0) begin
      if (n == idx) r = p;
      n++;
    end
    return r;
  endfunction
  function automatic logic [MAX_DW-1:0] col_mask(input int b);
    logic [MAX_DW-1:0] m;
    int p;
    for (int k = 0; k < MAX_DW; k++) begin
      p = data_pos(k);
      m[k] = p[b];
    end
    return m;
  endfunction
  function automatic logic [MAX_EW-1:0] gen_ecc(input logic [MAX_DW-1:0] data);
    logic [MAX_EW-1:0] e;
    for (int b = 0; b < MAX_EW; b++) e[b] = ^(data & col_mask(b));
    return e;
  endfunction
endpackage

// File: rtl/ecc_encoder_pipe_if.sv
// ecc_encoder_pipe_if: input/output stream, injection and counter signals of the encoder.
interface ecc_encoder_pipe_if #(parameter int DW = 32, parameter int EW = 6);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          inj_en;
  logic [DW+EW-1:0] inj_mask;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_ecc;
  logic [15:0]   word_cnt;
  modport master(output in_valid, in_data, inj_en, inj_mask, out_ready,
                 input in_ready, out_valid, out_data, out_ecc, word_cnt);
  modport slave(input in_valid, in_data, inj_en, inj_mask, out_ready,
                output in_ready, out_valid, out_data, out_ecc, word_cnt);
endinterface

// File: rtl/ecc_parity_gen.sv
// ecc_parity_gen: combinational even-parity check bits, one XOR tree per check bit.
module ecc_parity_gen
  import ecc_pkg::*;
#(
  parameter int DW = 32,
  parameter int EW = 6
) (
  input  logic [DW-1:0] i_data,
  output logic [EW-1:0] o_ecc
);
  for (genvar i = 0; i < EW; i++) begin : g_bit
    localparam logic [MAX_DW-1:0] M = col_mask(i);
    assign o_ecc[i] = ^(i_data & M[DW-1:0]);
  end
endmodule

// File: rtl/ecc_encoder_pipe.sv
// ecc_encoder_pipe: two-stage Hamming SEC encoder with valid/ready stream and error injection.
module ecc_encoder_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ECC_WIDTH  = 6
) (
  input logic clk,
  input logic rstb,
  ecc_encoder_pipe_if.slave bus
);
  localparam int CW = DATA_WIDTH + ECC_WIDTH;
  if (DATA_WIDTH < 4 || DATA_WIDTH > 64 || ECC_WIDTH != ecc_width(DATA_WIDTH)) begin : g_bad_cfg
    $error("ecc_encoder_pipe: illegal DATA_WIDTH/ECC_WIDTH combination");
  end
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic [CW-1:0]         r_s1_mask;
  logic                  r_s2_valid;
  logic [DATA_WIDTH-1:0] r_s2_data;
  logic [ECC_WIDTH-1:0]  r_s2_ecc;
  logic [15:0]           r_word_cnt;
  logic [ECC_WIDTH-1:0]  w_ecc;
  logic                  w_s2_load;
  logic                  w_in_fire;
  assign w_s2_load     = !r_s2_valid || bus.out_ready;
  assign bus.in_ready  = !r_s1_valid || w_s2_load;
  assign w_in_fire     = bus.in_valid && bus.in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign bus.out_ecc   = r_s2_ecc;
  assign bus.word_cnt  = r_word_cnt;
  ecc_parity_gen #(.DW(DATA_WIDTH), .EW(ECC_WIDTH)) u_parity (
    .i_data(r_s1_data),
    .o_ecc (w_ecc)
  );
  // The mask is gated at capture so a non-injected word carries an all-zero mask.
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mask  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_ecc   <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= bus.in_data;
        r_s1_mask  <= bus.inj_en ? bus.inj_mask : '0;
      end else if (w_s2_load) r_s1_valid <= 1'b0;
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= r_s1_data ^ r_s1_mask[CW-1:ECC_WIDTH];
          r_s2_ecc  <= w_ecc ^ r_s1_mask[ECC_WIDTH-1:0];
        end
      end
      if (r_s2_valid && bus.out_ready) r_word_cnt <= r_word_cnt + 16'd1;
    end
endmodule

// File: tb/tb_ecc_encoder_pipe.sv
// tb_ecc_encoder_pipe: directed checks of the ECC encoder using an independent syndrome decoder.
module tb_ecc_encoder_pipe;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  int checks = 0;
  int failures = 0;
  ecc_encoder_pipe_if #(.DW(32), .EW(6)) bus ();
  ecc_encoder_pipe #(.DATA_WIDTH(32), .ECC_WIDTH(6)) dut (.clk(clk), .rstb(rstb), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [31:0] decode(input logic [31:0] d, input logic [5:0] e);
    logic [38:0] cw;
    logic [31:0] r;
    int k, j, syn;
    cw = '0; k = 0; j = 0; syn = 0; r = '0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) == 0) begin cw[p] = e[j]; j++; end
      else begin cw[p] = d[k]; k++; end
    for (int p = 1; p <= 38; p++) if (cw[p]) syn ^= p;
    if (syn >= 1 && syn <= 38) cw[syn] = ~cw[syn];
    k = 0;
    for (int p = 3; p <= 38; p++) if ((p & (p - 1)) != 0) begin r[k] = cw[p]; k++; end
    return r;
  endfunction

  task automatic idle_inputs;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.inj_en = 1'b0; bus.inj_mask = '0; bus.out_ready = 1'b1;
  endtask

  task automatic do_reset;
    @(negedge clk); rstb = 1'b0; idle_inputs();
    @(negedge clk); @(negedge clk); rstb = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_one(input logic [31:0] d, input logic inj, input logic [37:0] m,
                          output int lat, output logic [31:0] od, output logic [5:0] oe);
    lat = -1; od = '0; oe = '0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d; bus.inj_en = inj; bus.inj_mask = m; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.inj_en = 1'b0; bus.inj_mask = '0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.out_valid) begin lat = c; od = bus.out_data; oe = bus.out_ecc; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk); rstb = 1'b0; idle_inputs(); #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.out_ecc !== 6'h0) begin failures++; $display("FAIL reset_out_ecc got=%b exp=0", bus.out_ecc); end
    checks++; if (bus.word_cnt !== 16'h0) begin failures++; $display("FAIL reset_word_cnt got=%h exp=0", bus.word_cnt); end
    @(negedge clk); @(negedge clk); rstb = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_vectors;
    logic [31:0] vd [5];
    logic [5:0]  ve [5];
    int lat;
    logic [31:0] od;
    logic [5:0] oe;
    vd = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h8000_0000};
    ve = '{6'b000000, 6'b000011, 6'b000101, 6'b000110, 6'b100110};
    for (int i = 0; i < 5; i++) begin
      send_one(vd[i], 1'b0, '0, lat, od, oe);
      checks++; if (lat != 2) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=2", i, lat); end
      checks++; if (oe !== ve[i]) begin failures++; $display("FAIL vec%0d_ecc got=%b exp=%b", i, oe, ve[i]); end
      checks++; if (od !== vd[i]) begin failures++; $display("FAIL vec%0d_data got=%h exp=%h", i, od, vd[i]); end
      checks++; if (bus.word_cnt !== 16'(i + 1)) begin failures++; $display("FAIL vec%0d_word_cnt got=%0d exp=%0d", i, bus.word_cnt, i + 1); end
    end
  endtask

  task automatic test_burst;
    logic [31:0] exp_q [$];
    logic [31:0] cur, e;
    int sent, got, first_cyc, last_cyc;
    do_reset();
    sent = 0; got = 0; first_cyc = -1; last_cyc = -1; cur = $urandom;
    for (int cyc = 0; cyc < 400 && got < 100; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b1; bus.in_valid = (sent < 100); bus.in_data = cur;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (decode(bus.out_data, bus.out_ecc) !== e) begin failures++; $display("FAIL burst_decode word=%0d got=%h exp=%h", got, decode(bus.out_data, bus.out_ecc), e); end
        checks++; if (bus.out_data !== e) begin failures++; $display("FAIL burst_data word=%0d got=%h exp=%h", got, bus.out_data, e); end
        if (got == 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin exp_q.push_back(cur); sent++; cur = $urandom; end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (got != 100) begin failures++; $display("FAIL burst_count got=%0d exp=100", got); end
    checks++; if (first_cyc != 2) begin failures++; $display("FAIL burst_fill got=%0d exp=2", first_cyc); end
    checks++; if (last_cyc != 101) begin failures++; $display("FAIL burst_rate last=%0d exp=101", last_cyc); end
    checks++; if (bus.word_cnt !== 16'd100) begin failures++; $display("FAIL burst_word_cnt got=%0d exp=100", bus.word_cnt); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_q [$];
    logic [31:0] cur, e, pd;
    logic [5:0] pe;
    logic stall, exp_rdy;
    int sent, got;
    do_reset();
    sent = 0; got = 0; stall = 1'b0; pd = '0; pe = '0; cur = $urandom;
    for (int cyc = 0; cyc < 2000 && got < 60; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid = (sent < 60) && ($urandom_range(0, 9) < 7);
      bus.in_data = cur;
      #1;
      exp_rdy = !((sent - got) == 2 && !bus.out_ready);
      checks++; if (bus.in_ready !== exp_rdy) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_rdy); end
      if (stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_ecc !== pe) begin
          failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc, bus.out_valid, bus.out_data, bus.out_ecc, pd, pe);
        end
      end
      stall = bus.out_valid && !bus.out_ready; pd = bus.out_data; pe = bus.out_ecc;
      if (bus.out_valid && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (decode(bus.out_data, bus.out_ecc) !== e) begin failures++; $display("FAIL bp_order word=%0d got=%h exp=%h", got, decode(bus.out_data, bus.out_ecc), e); end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin exp_q.push_back(cur); sent++; cur = $urandom; end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (got != 60) begin failures++; $display("FAIL bp_count got=%0d exp=60", got); end
    checks++; if (bus.word_cnt !== 16'd60) begin failures++; $display("FAIL bp_word_cnt got=%0d exp=60", bus.word_cnt); end
  endtask

  task automatic test_inject;
    int lat;
    logic [31:0] od;
    logic [5:0] oe;
    do_reset();
    @(negedge clk); bus.in_valid = 1'b0; bus.inj_en = 1'b1; bus.inj_mask = '1;
    @(negedge clk); idle_inputs();
    send_one(32'h0000_00C5, 1'b0, '0, lat, od, oe);
    checks++; if (od !== 32'h0000_00C5 || oe !== 6'b000010) begin failures++; $display("FAIL inj_ignored got=%h/%b exp=000000c5/000010", od, oe); end
    send_one(32'h0000_00C5, 1'b1, 38'h800, lat, od, oe);
    checks++; if (od !== 32'h0000_00E5 || oe !== 6'b000010) begin failures++; $display("FAIL inj_data_raw got=%h/%b exp=000000e5/000010", od, oe); end
    checks++; if (decode(od, oe) !== 32'h0000_00C5) begin failures++; $display("FAIL inj_data_corrected got=%h exp=000000c5", decode(od, oe)); end
    send_one(32'h0000_00C5, 1'b1, 38'h4, lat, od, oe);
    checks++; if (od !== 32'h0000_00C5 || oe !== 6'b000110) begin failures++; $display("FAIL inj_ecc_raw got=%h/%b exp=000000c5/000110", od, oe); end
    checks++; if (decode(od, oe) !== 32'h0000_00C5) begin failures++; $display("FAIL inj_ecc_corrected got=%h exp=000000c5", decode(od, oe)); end
  endtask

  task automatic test_reset_midstream;
    int seen;
    do_reset();
    @(negedge clk); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h1111_1111;
    @(negedge clk); bus.in_data = 32'h2222_2222;
    @(negedge clk); bus.in_valid = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%b exp=1", bus.out_valid); end
    #1 rstb = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", bus.out_valid); end
    @(negedge clk); rstb = 1'b1; bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (bus.out_valid) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL mid_stale_words got=%0d exp=0", seen); end
    checks++; if (bus.word_cnt !== 16'd0) begin failures++; $display("FAIL mid_word_cnt got=%0d exp=0", bus.word_cnt); end
  endtask

  task automatic test_counter;
    int lat;
    logic [31:0] od;
    logic [5:0] oe;
    do_reset();
    force dut.r_word_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_word_cnt;
    @(negedge clk);
    checks++; if (bus.word_cnt !== 16'hFFFF) begin failures++; $display("FAIL cnt_preload got=%h exp=ffff", bus.word_cnt); end
    send_one(32'h0000_0005, 1'b0, '0, lat, od, oe);
    checks++; if (oe !== 6'b000101) begin failures++; $display("FAIL cnt_ecc got=%b exp=000101", oe); end
    checks++; if (bus.word_cnt !== 16'h0000) begin failures++; $display("FAIL cnt_wrap got=%h exp=0000", bus.word_cnt); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_vectors();
    test_burst();
    test_backpressure();
    test_inject();
    test_reset_midstream();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
